bcd_score_arbiter: RTL and testbench
====================================

// Module: bcd_score_arbiter
// PURPOSE
//  Shares the six-digit BCD add/sub accumulator (decimalAddSubSixDigs) between N_REQ requesters.
//  Typical requesters: pickups, penalties, bonuses.
//  Round-robin arbitration grants one request at a time and drives enableAdd/enableSub/amountIn.
//  Saturates the running value at 000000 and 999999 and rejects non-BCD amounts.
//  Sits between game-logic event sources and the score/money accumulator.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
// PORTS
//  clk        in   1         system clock
//  resetN     in   1         reset, synchronous, active-low
//  reqIn      in   N_REQ     request level per requester, held until ackOut
//  subIn      in   N_REQ     1=subtract, 0=add; sampled with reqIn
//  amountIn   in   N_REQ*24  BCD amounts; requester r at [r*24 +: 24], same digit layout as scoreIn
//  scoreIn    in   24        accumulator resultOut (current value)
//  ackOut     out  N_REQ     one-cycle ack pulse to the served requester
//  enableAdd  out  1         to accumulator enableAdd
//  enableSub  out  1         to accumulator enableSub
//  amountOut  out  24        to accumulator amountIn
//  busy       out  1         1 in any state other than IDLE
//  satPulse   out  1         1-cycle pulse: last op was clamped
//  errPulse   out  1         1-cycle pulse: last request rejected (non-BCD digit)
// BEHAVIOUR
//  Digit layout: 24-bit vectors indexed [0:23]; digit k = bits [4k:4k+3].
//  Digit 0 is least significant; bit 4k is the digit MSB.
//  Magnitude compare is digit-wise, from digit 5 down to digit 0.
//  All outputs are registered; reset drives every output to 0, FSM to IDLE, and the RR pointer to 0.
//  Reset mid-operation aborts: no enable, no ack emitted afterwards.
//  FSM (all transitions on posedge clk):
//   IDLE:
//    - if any reqIn: pick the first set bit at or after rrPtr (wrap N_REQ-1 -> 0) and latch g.
//    - compute the op from scoreIn and amountIn[g]; go to ISSUE.
//   ISSUE:
//    - exactly one of enableAdd/enableSub = 1 with amountOut; ackOut[g] = 1.
//    - satPulse/errPulse = 1 if applicable; rrPtr <= (g+1) mod N_REQ; go to SETTLE.
//   SETTLE:
//    - enables 0; wait one cycle for the accumulator to update scoreIn; go to IDLE.
//  Throughput: one operation per 3 cycles. Grant-to-ack latency is 1 cycle after the IDLE decision.
//  Op computation (nc(x) = per-digit 9-d, the nines complement):
//   - Any amount digit >9: no enable in ISSUE; ack still given; errPulse = 1.
//   - Add, amount <= nc(score): amountOut = amount.
//   - Add, amount > nc(score): amountOut = nc(score), so the result is 999999; satPulse = 1.
//   - Sub, amount <= score: amountOut = amount.
//   - Sub, amount > score: amountOut = score, so the result is 000000; satPulse = 1.
//   - amount = 000000: the op is issued normally (no-op on the value), ack given.
//  Simultaneous requests: served strictly round-robin; none is starved beyond N_REQ-1 other grants.
//  A requester dropping reqIn before ack is simply skipped. A request re-asserted after ack is a new request.
//  enableAdd and enableSub are never both 1; outside ISSUE both are 0 and amountOut holds 0.
// TESTING
//  - Reset: hold resetN=0 with reqIn=1111 -> all outputs 0, no enable, busy=0; the first grant after release goes to r0.
//  - Add: score 000123, r1 add 000877 -> ISSUE 1 cycle later: enableAdd, amountOut=000877, ackOut=0010; score 001000.
//  - Saturation: score 999990, add 000050 -> amountOut=000009, satPulse, score 999999.
//  - Saturation: score 000040, sub 000100 -> amountOut=000040, satPulse, score 000000.
//  - Round-robin: reqIn=1111 held -> acks r0,r1,r2,r3,r0, one every 3 cycles; never both enables high.
//  - Bad BCD / reset mid-op: amount digit 0xA -> ack + errPulse, score unchanged.
//    resetN=0 during ISSUE -> next cycle enables 0, FSM IDLE.

Source files
------------

// File: rtl/bcd_score_arbiter_if.sv
// Requester/accumulator side bundle of the BCD score arbiter.
// 24-bit BCD vectors are ascending [0:23]: digit k sits at [4k:4k+3], bit 4k is its MSB.
interface bcd_score_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    reqIn;
  logic [N_REQ-1:0]    subIn;
  logic [0:N_REQ*24-1] amountIn;
  logic [0:23]         scoreIn;
  logic [N_REQ-1:0]    ackOut;
  logic                enableAdd;
  logic                enableSub;
  logic [0:23]         amountOut;
  logic                busy;
  logic                satPulse;
  logic                errPulse;

  modport master (
    output reqIn, subIn, amountIn, scoreIn,
    input  ackOut, enableAdd, enableSub, amountOut, busy, satPulse, errPulse
  );
  modport slave (
    input  reqIn, subIn, amountIn, scoreIn,
    output ackOut, enableAdd, enableSub, amountOut, busy, satPulse, errPulse
  );
endinterface

// File: rtl/bcd_score_arbiter.sv
// Round-robin arbiter sharing one six-digit BCD add/sub accumulator between N_REQ requesters,
// clamping results to 000000..999999 and rejecting non-BCD amounts.
module bcd_sat_digit (
  input  logic [3:0] s_dig,
  input  logic [3:0] a_dig,
  output logic [3:0] nc_dig,
  output logic       a_ok
);
  assign nc_dig = 4'd9 - s_dig;
  assign a_ok   = (a_dig <= 4'd9);
endmodule

module bcd_score_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic              clk,
  input  logic              resetN,
  bcd_score_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, g_q, g_d, sel;
  logic             found;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             add_q, add_d, sub_q, sub_d, sat_q, sat_d, err_q, err_d, busy_q, busy_d;
  logic [0:23]      amt_q, amt_d;
  logic [0:23]      amt_sel;
  logic [5:0][3:0]  s_dig, a_dig, nc_dig, res_dig;
  logic [5:0]       a_ok;

  // First pending request at or after the pointer, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.reqIn[(int'(ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign amt_sel = bus.amountIn[int'(sel)*24 +: 24];

  for (genvar k = 0; k < 6; k++) begin : g_dig
    assign s_dig[k] = bus.scoreIn[4*k +: 4];
    assign a_dig[k] = amt_sel[4*k +: 4];
  end

  bcd_sat_digit u_dig [5:0] (.s_dig(s_dig), .a_dig(a_dig), .nc_dig(nc_dig), .a_ok(a_ok));

  // Digit-wise magnitude compare, most significant digit first.
  function automatic logic bcd_gt(input logic [5:0][3:0] x, input logic [5:0][3:0] y);
    logic done, gt;
    done = 1'b0;
    gt   = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      if (!done && x[k] != y[k]) begin
        done = 1'b1;
        gt   = (x[k] > y[k]);
      end
    end
    return gt;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    ack_d   = '0;
    add_d   = 1'b0;
    sub_d   = 1'b0;
    sat_d   = 1'b0;
    err_d   = 1'b0;
    amt_d   = '0;
    res_dig = a_dig;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = sel;
          state_d = ISSUE;
          ack_d   = N_REQ'(1) << sel;
          if (!(&a_ok)) begin
            err_d = 1'b1;
          end else begin
            if (bus.subIn[sel]) begin
              sub_d = 1'b1;
              if (bcd_gt(a_dig, s_dig)) begin
                res_dig = s_dig;
                sat_d   = 1'b1;
              end
            end else begin
              add_d = 1'b1;
              // Adding the nines complement lands exactly on 999999.
              if (bcd_gt(a_dig, nc_dig)) begin
                res_dig = nc_dig;
                sat_d   = 1'b1;
              end
            end
            for (int k = 0; k < 6; k++) amt_d[4*k +: 4] = res_dig[k];
          end
        end
      end
      ISSUE: begin
        ptr_d   = (g_q == PW'(N_REQ-1)) ? '0 : g_q + 1'b1;
        state_d = SETTLE;
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      ack_q   <= '0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      ack_q   <= ack_d;
      add_q   <= add_d;
      sub_q   <= sub_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      amt_q   <= amt_d;
    end
  end

  assign bus.ackOut    = ack_q;
  assign bus.enableAdd = add_q;
  assign bus.enableSub = sub_q;
  assign bus.amountOut = amt_q;
  assign bus.busy      = busy_q;
  assign bus.satPulse  = sat_q;
  assign bus.errPulse  = err_q;
endmodule

// File: tb/tb_bcd_score_arbiter.sv
// Directed bench for bcd_score_arbiter with a decimal accumulator model feeding scoreIn.
module tb_bcd_score_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  bcd_score_arbiter_if #(.N_REQ(N)) bus ();
  bcd_score_arbiter #(.N_REQ(N)) dut (.clk(clk), .resetN(resetN), .bus(bus));

  int total = 0;
  int bad = 0;
  int cur = 0;
  int acc = 0;
  logic load_en = 1'b0;
  int load_val = 0;
  logic both_seen = 1'b0;

  typedef struct {
    int        score;
    int        r;
    bit        sub;
    bit [23:0] amt;
    bit        e_add;
    bit        e_sub;
    bit [23:0] e_amt;
    bit        e_sat;
    bit        e_err;
    int        e_score;
  } vec_t;
  vec_t vt[12];

  function automatic logic [0:23] enc(input int v);
    logic [0:23] r;
    int t;
    t = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int dec(input logic [0:23] x);
    int s, m;
    s = 0;
    m = 1;
    for (int k = 0; k < 6; k++) begin
      s = s + int'(x[4*k +: 4]) * m;
      m = m * 10;
    end
    return s;
  endfunction

  function automatic logic [0:23] hx(input logic [23:0] h);
    logic [0:23] r;
    for (int k = 0; k < 6; k++) r[4*k +: 4] = h[4*k +: 4];
    return r;
  endfunction

  function automatic int unhx(input logic [0:23] x);
    logic [23:0] h;
    for (int k = 0; k < 6; k++) h[4*k +: 4] = x[4*k +: 4];
    return int'(h);
  endfunction

  always @(posedge clk) begin
    if (load_en) acc <= load_val;
    else if (bus.enableAdd) acc <= acc + dec(bus.amountOut);
    else if (bus.enableSub) acc <= acc - dec(bus.amountOut);
  end
  always_comb bus.scoreIn = enc(acc);

  always @(negedge clk) if (bus.enableAdd && bus.enableSub) both_seen <= 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL v%0d %s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask

  task automatic set_score(input int v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    set_score(v.score);
    bus.amountIn = '0;
    bus.amountIn[v.r*24 +: 24] = hx(v.amt);
    bus.subIn = '0;
    bus.subIn[v.r] = v.sub;
    bus.reqIn = 4'(1 << v.r);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.ackOut == '0 && lat < 10);
    chk("latency", lat, 1);
    chk("ack", int'(bus.ackOut), 1 << v.r);
    chk("enableAdd", int'(bus.enableAdd), int'(v.e_add));
    chk("enableSub", int'(bus.enableSub), int'(v.e_sub));
    chk("amountOut", unhx(bus.amountOut), int'(v.e_amt));
    chk("satPulse", int'(bus.satPulse), int'(v.e_sat));
    chk("errPulse", int'(bus.errPulse), int'(v.e_err));
    chk("busy_issue", int'(bus.busy), 1);
    bus.reqIn = '0;
    @(negedge clk);
    chk("settle_quiet", int'(bus.enableAdd | bus.enableSub | (bus.amountOut != '0) |
        (bus.ackOut != '0) | bus.satPulse | bus.errPulse), 0);
    chk("busy_settle", int'(bus.busy), 1);
    @(negedge clk);
    chk("score", acc, v.e_score);
    chk("busy_idle", int'(bus.busy), 0);
  endtask

  initial begin
    int acks[5];
    int cycs[5];
    int na;
    int lat;
    vt[0]  = '{123,    1, 0, 24'h000877, 1, 0, 24'h000877, 0, 0, 1000};
    vt[1]  = '{999990, 2, 0, 24'h000050, 1, 0, 24'h000009, 1, 0, 999999};
    vt[2]  = '{40,     3, 1, 24'h000100, 0, 1, 24'h000040, 1, 0, 0};
    vt[3]  = '{500,    0, 1, 24'h000200, 0, 1, 24'h000200, 0, 0, 300};
    vt[4]  = '{5,      1, 0, 24'h00000A, 0, 0, 24'h000000, 0, 1, 5};
    vt[5]  = '{777,    2, 0, 24'h000000, 1, 0, 24'h000000, 0, 0, 777};
    vt[6]  = '{999999, 3, 0, 24'h000001, 1, 0, 24'h000000, 1, 0, 999999};
    vt[7]  = '{0,      0, 1, 24'h000000, 0, 1, 24'h000000, 0, 0, 0};
    vt[8]  = '{123456, 1, 1, 24'h123456, 0, 1, 24'h123456, 0, 0, 0};
    vt[9]  = '{450000, 2, 0, 24'h549999, 1, 0, 24'h549999, 0, 0, 999999};
    vt[10] = '{100,    3, 1, 24'h0A0000, 0, 0, 24'h000000, 0, 1, 100};
    vt[11] = '{90,     0, 0, 24'h000910, 1, 0, 24'h000910, 0, 0, 1000};

    // Reset held with every requester asserted.
    bus.reqIn = 4'b1111;
    bus.subIn = '0;
    bus.amountIn = '0;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(bus.ackOut), 0);
    chk("rst_enables", int'({bus.enableAdd, bus.enableSub}), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pulses", int'({bus.satPulse, bus.errPulse}), 0);
    chk("rst_amount", unhx(bus.amountOut), 0);

    // Round-robin with all requests held.
    resetN = 1'b1;
    na = 0;
    for (int c = 1; c <= 40 && na < 5; c++) begin
      @(negedge clk);
      if (bus.ackOut != '0) begin
        acks[na] = int'(bus.ackOut);
        cycs[na] = c;
        na++;
      end
    end
    cur = 100;
    chk("rr_count", na, 5);
    for (int i = 0; i < na; i++) begin
      chk("rr_ack", acks[i], 1 << (i % 4));
      if (i == 0) chk("rr_first_cycle", cycs[i], 1);
      else chk("rr_spacing", cycs[i] - cycs[i-1], 3);
    end
    bus.reqIn = '0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      cur = i;
      run_vec(vt[i]);
    end

    // Reset asserted while ISSUE is active.
    cur = 200;
    set_score(10);
    bus.amountIn = '0;
    bus.amountIn[2*24 +: 24] = hx(24'h000005);
    bus.reqIn = 4'b0100;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.ackOut == '0 && lat < 10);
    chk("midop_ack", int'(bus.ackOut), 4'b0100);
    resetN = 1'b0;
    bus.reqIn = 4'b1111;
    @(negedge clk);
    chk("midop_enables", int'({bus.enableAdd, bus.enableSub}), 0);
    chk("midop_ack_after", int'(bus.ackOut), 0);
    chk("midop_busy", int'(bus.busy), 0);
    resetN = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.ackOut == '0 && lat < 10);
    chk("post_reset_grant", int'(bus.ackOut), 4'b0001);
    bus.reqIn = '0;
    repeat (3) @(negedge clk);

    chk("no_dual_enable", int'(both_seen), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
